// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
// Optional auto-repeat is selected by the KEYPAD_AUTOREPEAT_EN macro (see keypad_scan_ctrl).
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } keypad_state_e;

  typedef struct packed {
    logic [2:0] idx;  // index of the highest set bit
    logic       one;  // exactly one bit set
  } onehot_res_t;

  // Locate the set bit of a row vector and report whether it is the only one.
  function automatic onehot_res_t onehot_idx(input logic [7:0] v);
    onehot_res_t r;
    logic [3:0]  n;
    r.idx = 3'd0;
    n     = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        r.idx = 3'(i);
        n     = n + 4'd1;
      end
    end
    r.one = (n == 4'd1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_db_counter.sv
// Enable/clear counter that saturates at MAX; done flags the saturated value.
// Used for dwell/debounce timing and for auto-repeat timing.
module keypad_db_counter #(
  parameter int  MAX = 7,
  localparam int W   = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  // Clear wins over enable; counting stops at MAX so the value never wraps.
  always_comb begin
    count_d = count_q;
    if (clr)                          count_d = '0;
    else if (en && (count_q != W'(MAX))) count_d = count_q + 1'b1;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign done  = (count_q == W'(MAX));

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: row synchroniser, column scan, press/release debounce,
// multi-key error flag. Define KEYPAD_AUTOREPEAT_EN to re-strobe key_valid while a key is held.
// Handshake: key_valid is a one-cycle strobe with no back-pressure; key_code is valid
// whenever key_valid is high and holds its value between strobes.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int  NROWS      = 4,
  parameter int  NCOLS      = 4,
  parameter int  DWELL      = 1000,
  parameter int  DB_CYCLES  = 20000,
  parameter int  REPEAT_DLY = 500000,
  parameter int  REPEAT_PER = 100000,
  localparam int KW         = $clog2(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NROWS-1:0] row_in,
  output logic [NCOLS-1:0] col_drv,
  output logic             key_valid,
  output logic [KW-1:0]    key_code,
  output logic             key_held,
  output logic             error_led,
  output keypad_state_e    dbg_state
);

  localparam int CW       = $clog2(NCOLS);
  localparam int MAIN_MAX = ((DWELL > DB_CYCLES) ? DWELL : DB_CYCLES) - 1;
  localparam int MW       = $clog2(MAIN_MAX) + 1;

  keypad_state_e    state_q, state_d;
  logic [NROWS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]    col_q, col_d, col_next;
  logic [2:0]       row_q, row_d;
  logic [KW-1:0]    key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             err_q, err_d;

  logic [NROWS-1:0] rs, row_mask;
  logic             hit, others;
  onehot_res_t      oh;
  logic [MW-1:0]    cnt;
  logic             cnt_en, cnt_clr, cnt_done;
  logic             dwell_end, db_end;
  logic             rep_fire;

  // One counter shared by dwell and debounce; it is cleared on every state change,
  // so saturation only acts as a backstop for the larger of the two terminals.
  keypad_db_counter #(.MAX(MAIN_MAX)) u_main_cnt (
    .clk(clk), .reset(reset), .en(cnt_en), .clr(cnt_clr), .count(cnt), .done(cnt_done)
  );

  // Decode synchronised rows against the captured key and the current counter.
  always_comb begin
    sync1_d   = row_in;
    sync2_d   = sync1_q;
    rs        = sync2_q;
    row_mask  = NROWS'(1) << row_q;
    hit       = |(rs & row_mask);
    others    = |(rs & ~row_mask);
    oh        = onehot_idx(8'(rs));
    col_next  = (col_q == CW'(NCOLS - 1)) ? '0 : col_q + 1'b1;
    dwell_end = cnt_done || (cnt == MW'(DWELL - 1));
    db_end    = cnt_done || (cnt == MW'(DB_CYCLES - 1));
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = ((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER) - 1;
  localparam int RW      = $clog2(REP_MAX) + 1;

  logic [RW-1:0] rep_cnt, rep_target;
  logic          rep_en, rep_clr, rep_done;
  logic          rep_first_q, rep_first_d;

  keypad_db_counter #(.MAX(REP_MAX)) u_rep_cnt (
    .clk(clk), .reset(reset), .en(rep_en), .clr(rep_clr), .count(rep_cnt), .done(rep_done)
  );

  // Repeat timer runs in HELD, pauses in REL_DB, restarts whenever the key is lost.
  always_comb begin
    rep_target  = rep_first_q ? RW'(REPEAT_PER - 1) : RW'(REPEAT_DLY - 1);
    rep_fire    = (state_q == HELD) && (rep_done || (rep_cnt == rep_target));
    rep_en      = (state_q == HELD) && !rep_fire;
    rep_clr     = rep_fire || (state_q == SCAN) || (state_q == PRESS_DB);
    rep_first_d = rep_first_q;
    if ((state_q == SCAN) || (state_q == PRESS_DB)) rep_first_d = 1'b0;
    else if (rep_fire)                              rep_first_d = 1'b1;
  end

  // Tracks whether the initial repeat delay has already elapsed.
  always_ff @(posedge clk) begin
    if (!reset) rep_first_q <= 1'b0;
    else        rep_first_q <= rep_first_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Scanner FSM: next state, column, capture and output strobes.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    err_d       = err_q;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_end) begin
          cnt_clr = 1'b1;
          if (rs == '0) begin
            col_d = col_next;
          end else if (oh.one) begin
            row_d   = oh.idx;
            state_d = PRESS_DB;
          end else begin
            err_d = 1'b1;
            col_d = col_next;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      PRESS_DB: begin
        if (rs != row_mask) begin
          cnt_clr = 1'b1;
          col_d   = col_next;
          state_d = SCAN;
        end else if (db_end) begin
          cnt_clr     = 1'b1;
          key_valid_d = 1'b1;
          key_code_d  = KW'(int'(row_q) * NCOLS + int'(col_q));
          key_held_d  = 1'b1;
          err_d       = 1'b0;
          state_d     = HELD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HELD: begin
        cnt_clr     = 1'b1;
        key_valid_d = rep_fire;
        if (others) err_d   = 1'b1;
        if (!hit)   state_d = REL_DB;
      end
      REL_DB: begin
        if (hit) begin
          cnt_clr = 1'b1;
          state_d = HELD;
        end else if (db_end) begin
          cnt_clr    = 1'b1;
          key_held_d = 1'b0;
          col_d      = col_next;
          state_d    = SCAN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State and output registers; reset overrides everything on its edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= SCAN;
      col_q       <= '0;
      row_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      err_q       <= err_d;
    end
  end

  assign col_drv   = NCOLS'(1) << col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign error_led = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl with a behavioural 4x4 key matrix.
// Build with KEYPAD_AUTOREPEAT_EN defined to also expect the repeat strobes.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int DB = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    row_in = '0;
  logic [3:0]    col_drv;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_held;
  logic          error_led;
  keypad_state_e dbg_state;

  keypad_scan_ctrl #(
    .NROWS(4), .NCOLS(4), .DWELL(4), .DB_CYCLES(DB), .REPEAT_DLY(40), .REPEAT_PER(16)
  ) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_drv(col_drv), .key_valid(key_valid),
    .key_code(key_code), .key_held(key_held), .error_led(error_led), .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         tests = 0;
  int         fails = 0;
  int         strobe_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic [15:0] keys = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every strobe must match the oldest expected key code and last one cycle.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      strobe_cnt++;
      if (prev_valid) begin
        tests++;
        fails++;
        $display("FAIL strobe_width: key_valid high on consecutive cycles");
      end
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got code %0d expected no strobe", key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        check("strobe_key_code", 32'(key_code), 32'(mon_exp));
      end
    end
    prev_valid = key_valid;
  end

  // ---------------- drivers ----------------
  function automatic logic [3:0] matrix(input logic [15:0] k, input logic [3:0] cd);
    logic [3:0] r;
    r = '0;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && cd[ci]) r[ri] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    row_in = matrix(keys, col_drv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_strobe(input int budget, input string name, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < budget) begin
      step();
      lat++;
      if (key_valid) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_held(input logic val, input int budget, input string name, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < budget) begin
      step();
      lat++;
      if (key_held == val) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic press_release(input int r, input int c, input logic [3:0] code);
    int lat;
    keys = 16'(1) << (r * 4 + c);
    exp_q.push_back(code);
    wait_strobe(40, "press_strobe", lat);
    check("press_key_held", 32'(key_held), 32'd1);
    keys = '0;
    wait_held(1'b0, 40, "release_done", lat);
    check("resume_next_col", 32'(col_drv), 32'(4'b0001 << ((c + 1) % 4)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_drv"},   32'(col_drv),   32'd1);
    check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_key_held"},  32'(key_held),  32'd0);
    check({tag, "_error_led"}, 32'(error_led), 32'd0);
    check({tag, "_key_code"},  32'(key_code),  32'd0);
    check({tag, "_state"},     32'(dbg_state), 32'(SCAN));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         row;
    int         col;
    logic [3:0] exp_code;
  } press_vec_t;

  press_vec_t vecs[6];

  initial begin
    int lat;
    int base;
    int n;
    int extra;

    vecs[0] = '{0, 0, 4'd0};
    vecs[1] = '{3, 3, 4'd15};
    vecs[2] = '{1, 2, 4'd6};
    vecs[3] = '{0, 3, 4'd3};
    vecs[4] = '{3, 0, 4'd12};
    vecs[5] = '{2, 2, 4'd10};

    // 1: reset values and free-running column scan
    reset = 1'b0;
    idle(2);
    check_reset_outputs("reset");
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("scan_col_drv", 32'(col_drv), 32'(4'b0001 << ((i / 4) % 4)));
      step();
    end

    // 2: single clean press of r2,c1 gives exactly one strobe
    base = strobe_cnt;
    keys = 16'(1) << 9;
    exp_q.push_back(4'd9);
    wait_strobe(40, "key9_strobe", lat);
    check("key9_code", 32'(key_code), 32'd9);
    check("key9_held", 32'(key_held), 32'd1);
    idle(20);
    check("key9_single_strobe", 32'(strobe_cnt - base), 32'd1);
    keys = '0;
    wait_held(1'b0, 40, "key9_release", lat);
    idle(6);

    // 3: bouncing press, final bounce phase released, then steady
    for (int i = 0; i < 30; i++) begin
      keys = (((i / 3) % 2) == 0) ? (16'(1) << 9) : 16'd0;
      step();
    end
    keys = 16'(1) << 9;
    exp_q.push_back(4'd9);
    wait_strobe(60, "bounce_strobe", lat);
    check("bounce_latency_min", 32'(lat >= DB + 2), 32'd1);

    // 4: release with chatter; key_held stays up, then drops after debounce
    for (int i = 0; i < 5; i++) begin
      keys = ((i % 2) == 0) ? 16'd0 : (16'(1) << 9);
      step();
      check("chatter_held", 32'(key_held), 32'd1);
    end
    keys = '0;
    wait_held(1'b0, 30, "chatter_release", lat);
    check("chatter_release_window", 32'(lat >= DB && lat <= DB + 4), 32'd1);
    check("resume_col2", 32'(col_drv), 32'b0100);

    // table of single presses
    foreach (vecs[i]) press_release(vecs[i].row, vecs[i].col, vecs[i].exp_code);

    // 5: two keys in column 0 -> error, no strobe; clean key 0 clears it
    keys = 16'h0011;
    n = 0;
    while (!error_led && n < 40) begin
      step();
      n++;
    end
    check("multikey_error", 32'(error_led), 32'd1);
    idle(20);
    keys = '0;
    idle(4);
    check("error_sticky", 32'(error_led), 32'd1);
    keys = 16'h0001;
    exp_q.push_back(4'd0);
    wait_strobe(40, "key0_strobe", lat);
    check("key0_code", 32'(key_code), 32'd0);
    check("key0_error_cleared", 32'(error_led), 32'd0);
    keys = '0;
    wait_held(1'b0, 40, "key0_release", lat);

    // 6a: reset during PRESS_DB with error_led set
    keys = 16'h0011;
    n = 0;
    while (!error_led && n < 40) begin
      step();
      n++;
    end
    keys = 16'(1) << 5;
    n = 0;
    while (dbg_state != PRESS_DB && n < 40) begin
      step();
      n++;
    end
    check("reach_press_db", 32'(dbg_state), 32'(PRESS_DB));
    check("pre_reset_error", 32'(error_led), 32'd1);
    keys  = '0;
    reset = 1'b0;
    step();
    check_reset_outputs("rst_press_db");
    reset = 1'b1;
    idle(10);

    // 6b: reset during HELD
    keys = 16'(1) << 5;
    exp_q.push_back(4'd5);
    wait_strobe(40, "key5_strobe", lat);
    idle(2);
    check("key5_held", 32'(dbg_state), 32'(HELD));
    keys  = '0;
    reset = 1'b0;
    step();
    check_reset_outputs("rst_held");
    reset = 1'b1;
    idle(20);

    // long hold of key 5: repeat strobes only with auto-repeat enabled
`ifdef KEYPAD_AUTOREPEAT_EN
    extra = 2;
`else
    extra = 0;
`endif
    base = strobe_cnt;
    keys = 16'(1) << 5;
    for (int i = 0; i <= extra; i++) exp_q.push_back(4'd5);
    wait_strobe(40, "hold_strobe", lat);
    idle(60);
    check("hold_strobe_count", 32'(strobe_cnt - base), 32'(1 + extra));
    keys = '0;
    wait_held(1'b0, 40, "hold_release", lat);
    idle(4);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
